// File: rtl/host_spi_regif.sv
// SPI slave (CPHA=0) turning host frames into register write/read strobes on master_clk.
// Macro HOST_SPI_READBACK_EN enables the register readback path; otherwise SOMI loops back SIMO.
module host_spi_regif #(
    parameter int ADDR_W = 7,
    parameter int WORD_W = 16,
    parameter int CPOL   = 0
) (
    input  logic              master_clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_simo,
    input  logic              spi_cs_n,
    output logic              spi_somi,
    output logic              spi_somi_oe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              rd_strobe,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              frame_err
);

    localparam int FRAME_LEN = 1 + ADDR_W + WORD_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_LAST_ADDR   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME       = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_FIRST_SHIFT = CNT_W'(ADDR_W + 2);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    logic sclk_p0, sclk_p1, sclk_p2;
    logic simo_p0, simo_p1;
    logic cs_p0, cs_p1, cs_p2;
    logic armed;
    logic sample_edge, cs_fall, cs_rise;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rnw;
    logic [ADDR_W-1:0] addr_sr, addr_shift;
    logic [WORD_W-2:0] data_sr;
    logic [WORD_W-1:0] data_shift;

    // Synchronisers clear to 0; a cs falling edge therefore needs cs seen high first.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
            simo_p0 <= 1'b0; simo_p1 <= 1'b0;
            cs_p0   <= 1'b0; cs_p1   <= 1'b0; cs_p2   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sclk_p0 <= spi_clk;  sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
            simo_p0 <= spi_simo; simo_p1 <= simo_p0;
            cs_p0   <= spi_cs_n; cs_p1   <= cs_p0;   cs_p2   <= cs_p1;
            armed   <= armed | cs_p1;
        end
    end

    assign sample_edge = (CPOL == 0) ? (sclk_p1 & ~sclk_p2) : (~sclk_p1 & sclk_p2);
    assign cs_fall     = ~cs_p1 & cs_p2;
    assign cs_rise     = cs_p1 & ~cs_p2;

    generate
        if (ADDR_W > 1) begin : g_addr_wide
            assign addr_shift = {addr_sr[ADDR_W-2:0], simo_p1};
        end else begin : g_addr_one
            assign addr_shift = simo_p1;
        end
    endgenerate
    assign data_shift = {data_sr, simo_p1};

`ifdef HOST_SPI_READBACK_EN
    logic              shift_edge;
    logic              rd_load;
    logic [WORD_W-1:0] somi_sr;
    assign shift_edge = (CPOL == 0) ? (~sclk_p1 & sclk_p2) : (sclk_p1 & ~sclk_p2);
`else
    logic loop_bit;
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
`endif

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rnw         <= 1'b0;
            addr_sr     <= '0;
            data_sr     <= '0;
            spi_somi    <= 1'b0;
            spi_somi_oe <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_strobe   <= 1'b0;
            rd_addr     <= '0;
            frame_err   <= 1'b0;
`ifdef HOST_SPI_READBACK_EN
            rd_load     <= 1'b0;
            somi_sr     <= '0;
`else
            loop_bit    <= 1'b0;
`endif
        end else begin
            wr_strobe   <= 1'b0;
            rd_strobe   <= 1'b0;
            frame_err   <= 1'b0;
            spi_somi_oe <= armed & ~cs_p1;
            if (cs_fall) begin
                state <= CMD;
                cnt   <= '0;
`ifndef HOST_SPI_READBACK_EN
                loop_bit <= 1'b0;
`endif
            end else if (cs_rise) begin
                // Short frames never reach DONE; long frames saturate the counter past FRAME_LEN.
                if (state != IDLE && (state != DONE || cnt > CNT_FRAME))
                    frame_err <= 1'b1;
                state <= IDLE;
            end else if (sample_edge && state != IDLE) begin
                if (cnt <= CNT_FRAME)
                    cnt <= cnt + CNT_W'(1);
`ifndef HOST_SPI_READBACK_EN
                loop_bit <= simo_p1;
`endif
                case (state)
                    CMD: begin
                        rnw   <= simo_p1;
                        state <= ADDR;
                    end
                    ADDR: begin
                        addr_sr <= addr_shift;
                        if (cnt == CNT_LAST_ADDR) begin
                            state <= DATA;
`ifdef HOST_SPI_READBACK_EN
                            if (rnw) begin
                                rd_strobe <= 1'b1;
                                rd_addr   <= addr_shift;
                            end
`endif
                        end
                    end
                    DATA: begin
                        data_sr <= data_shift[WORD_W-2:0];
                        if (cnt == CNT_LAST_DATA) begin
                            state <= DONE;
                            if (!rnw) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr_sr;
                                wr_data   <= data_shift;
                            end
                        end
                    end
                    default: ;
                endcase
            end
`ifdef HOST_SPI_READBACK_EN
            // The shift edge before the first data sample presents the MSB, so it must not shift.
            rd_load <= rd_strobe;
            if (rd_load)
                somi_sr <= rd_data;
            else if (shift_edge && state == DATA && cnt >= CNT_FIRST_SHIFT)
                somi_sr <= {somi_sr[WORD_W-2:0], 1'b0};
            spi_somi <= (state == DATA && rnw) ? somi_sr[WORD_W-1] : 1'b0;
`else
            spi_somi <= (state inside {CMD, ADDR, DATA}) ? loop_bit : 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_host_spi_regif.sv
// Randomised scoreboard bench for host_spi_regif: a default instance and a CPOL=1, 4/8-bit instance
// share SCK/SIMO with separate chip selects.
module tb_host_spi_regif;

    localparam int AW = 7, WW = 16, FL = 1 + AW + WW;
    localparam int AWB = 4, WWB = 8, FLB = 1 + AWB + WWB;

    logic master_clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0, simo = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
    logic spi_clk_b;
    assign spi_clk_b = ~sck;

    logic          somi_a, oe_a, wr_strobe_a, rd_strobe_a, frame_err_a;
    logic [AW-1:0] wr_addr_a, rd_addr_a;
    logic [WW-1:0] wr_data_a;
    logic [WW-1:0] rd_data_a = '0;
    logic           somi_b, oe_b, wr_strobe_b, rd_strobe_b, frame_err_b;
    logic [AWB-1:0] wr_addr_b, rd_addr_b;
    logic [WWB-1:0] wr_data_b;
    logic [WWB-1:0] rd_data_b = '0;

    int checks = 0, errors = 0;

    typedef struct { int kind; int addr; int data; } ev_t;  // kind: 0 write, 1 read, 2 frame_err
    ev_t qa[$], qb[$];
    logic [15:0] rd_val = '0;
    logic        rd_prev = 1'b0;

    always #5 master_clk = ~master_clk;

    host_spi_regif dut_a (
        .master_clk(master_clk), .reset(reset), .spi_clk(sck), .spi_simo(simo), .spi_cs_n(cs_a),
        .spi_somi(somi_a), .spi_somi_oe(oe_a), .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .rd_strobe(rd_strobe_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .frame_err(frame_err_a));

    host_spi_regif #(.ADDR_W(AWB), .WORD_W(WWB), .CPOL(1)) dut_b (
        .master_clk(master_clk), .reset(reset), .spi_clk(spi_clk_b), .spi_simo(simo), .spi_cs_n(cs_b),
        .spi_somi(somi_b), .spi_somi_oe(oe_b), .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .rd_strobe(rd_strobe_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .frame_err(frame_err_b));

    // Register file answers in the cycle after rd_strobe; other cycles carry junk.
    always @(posedge master_clk) begin
        #1;
        rd_data_a = rd_prev ? rd_val : 16'($urandom);
        rd_prev   = rd_strobe_a;
    end

    task automatic push(input int sel, input int kind, input int a, input int d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        if (sel == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic check_ev(input int sel, input int kind, input int a, input int d);
        ev_t e;
        checks++;
        if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL event dut%0d: got kind %0d addr %0h data %0h, required no event", sel, kind, a, d);
        end else begin
            if (sel == 0) e = qa.pop_front(); else e = qb.pop_front();
            if (e.kind != kind || e.addr != a || e.data != d) begin
                errors++;
                $display("FAIL event dut%0d: got kind %0d addr %0h data %0h, required kind %0d addr %0h data %0h",
                         sel, kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge master_clk) begin
        if (!reset) begin
            if (wr_strobe_a) check_ev(0, 0, int'(wr_addr_a), int'(wr_data_a));
            if (rd_strobe_a) check_ev(0, 1, int'(rd_addr_a), 0);
            if (frame_err_a) check_ev(0, 2, 0, 0);
            if (wr_strobe_b) check_ev(1, 0, int'(wr_addr_b), int'(wr_data_b));
            if (rd_strobe_b) check_ev(1, 1, int'(rd_addr_b), 0);
            if (frame_err_b) check_ev(1, 2, 0, 0);
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic check_reset_vals();
        logic [34:0] va;
        logic [20:0] vb;
        va = {somi_a, oe_a, wr_strobe_a, rd_strobe_a, frame_err_a, wr_addr_a, wr_data_a, rd_addr_a};
        vb = {somi_b, oe_b, wr_strobe_b, rd_strobe_b, frame_err_b, wr_addr_b, wr_data_b, rd_addr_b};
        checks += 2;
        if (va !== '0) begin errors++; $display("FAIL reset_vals_a: got %h, required 0", va); end
        if (vb !== '0) begin errors++; $display("FAIL reset_vals_b: got %h, required 0", vb); end
    endtask

    task automatic half();
        #83;
    endtask

    // One host frame of n sample edges; abort_at >= 0 asserts reset after that many edges.
    task automatic frame(input int sel, input int rnw, input int addr, input int data,
                         input int n, input int abort_at);
        int aw, fl;
        logic [63:0] fb, cap, expc, mask;
        bit aborted;
        aw = sel ? AWB : AW;
        fl = sel ? FLB : FL;
        fb = {$urandom(), $urandom()};
        fb[0] = rnw[0];
        for (int k = 1; k <= aw; k++) fb[k] = addr[aw-k];
        for (int k = aw + 1; k < fl; k++) fb[k] = data[fl-1-k];
        if (sel == 0 && rnw != 0) rd_val = data[15:0];
        if (abort_at < 0) begin
            if (rnw == 0 && n >= fl) push(sel, 0, addr, data);
`ifdef HOST_SPI_READBACK_EN
            if (rnw != 0 && n >= aw + 1) push(sel, 1, addr, 0);
`endif
            if (n != fl) push(sel, 2, 0, 0);
        end
        expc = '0;
        for (int k = 0; k < n && k < fl; k++) begin
`ifdef HOST_SPI_READBACK_EN
            if (rnw != 0 && k > aw) expc[k] = data[fl-1-k];
`else
            if (k >= 1) expc[k] = fb[k-1];
`endif
        end
        cap = '0;
        aborted = 1'b0;
        if (sel == 0) cs_a = 1'b0; else cs_b = 1'b0;
        simo = fb[0];
        half();
        check_bit("oe_in_frame", sel ? oe_b : oe_a, 1'b1);
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                aborted = 1'b1;
                break;
            end
            cap[k] = sel ? somi_b : somi_a;
            sck = 1'b1;
            half();
            sck = 1'b0;
            simo = fb[k+1];
            half();
        end
        if (aborted) begin
            reset = 1'b1;
            repeat (3) @(posedge master_clk);
            cs_a = 1'b1; cs_b = 1'b1; simo = 1'b0;
            repeat (3) @(posedge master_clk);
            #1 check_reset_vals();
            @(negedge master_clk) reset = 1'b0;
            half(); half();
        end else begin
            cs_a = 1'b1; cs_b = 1'b1; simo = 1'b0;
            half(); half();
            check_bit("oe_after_frame", sel ? oe_b : oe_a, 1'b0);
            mask = (64'd1 << n) - 64'd1;
            checks++;
            if ((cap & mask) !== (expc & mask)) begin
                errors++;
                $display("FAIL somi_capture dut%0d n=%0d: got %h, required %h", sel, n, cap & mask, expc & mask);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, rnw, n, r;
        repeat (5) @(posedge master_clk);
        #1 check_reset_vals();
        @(negedge master_clk) reset = 1'b0;
        repeat (10) @(posedge master_clk);

        frame(0, 0, 'h15, 'hBEEF, FL, -1);
        frame(0, 1, 'h02, 'hA5C3, FL, -1);
        frame(0, 0, 'h33, 'h4444, 10, -1);
        frame(0, 0, 'h01, 'h0001, FL, -1);
        frame(0, 0, 'h55, 'h6666, FL, 12);
        frame(0, 0, 'h7F, 'h1234, FL, -1);
        frame(1, 0, 'h9, 'h3C, FLB, -1);
        frame(0, 0, 'h10, 'h00FF, FL + 2, -1);

        for (int i = 0; i < 24; i++) begin
            sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r = $urandom_range(0, 9);
            if (sel == 0) begin
                n = (r < 6) ? FL : (r < 8) ? $urandom_range(0, FL - 1) : $urandom_range(FL + 1, FL + 4);
                rnw = $urandom_range(0, 1);
                frame(0, rnw, $urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << WW) - 1), n, -1);
            end else begin
                n = (r < 6) ? FLB : (r < 8) ? $urandom_range(0, FLB - 1) : $urandom_range(FLB + 1, FLB + 4);
                frame(1, 0, $urandom_range(0, (1 << AWB) - 1), $urandom_range(0, (1 << WWB) - 1), n, -1);
            end
        end

        repeat (20) @(posedge master_clk);
        checks += 2;
        if (qa.size() != 0) begin errors++; $display("FAIL pending_a: got %0d events left, required 0", qa.size()); end
        if (qb.size() != 0) begin errors++; $display("FAIL pending_b: got %0d events left, required 0", qb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_spi_regif.md
HOST_SPI_REGIF -- requirements
Module: host_spi_regif

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 7: register address width in bits, legal range 1..15.
REQ-002 The block SHALL have parameter WORD_W, default 16: register data width in bits, legal range 8..32.
REQ-003 The block SHALL have parameter CPOL, default 0: SPI clock idle level; 0 or 1, with data sampled on the leading edge (CPHA=0) in both cases.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have master_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have spi_clk, input, 1 bit: host SPI clock, asynchronous to master_clk.
REQ-007 The block SHALL have spi_simo, input, 1 bit: host-to-slave data, MSB first.
REQ-008 The block SHALL have spi_cs_n, input, 1 bit: active-low frame select.
REQ-009 The block SHALL have spi_somi, output, 1 bit: slave-to-host data.
REQ-010 The block SHALL have spi_somi_oe, output, 1 bit: output enable for spi_somi; high while the synchronised spi_cs_n is low.
REQ-011 The block SHALL have wr_strobe, output, 1 bit: one-cycle register write pulse.
REQ-012 The block SHALL have wr_addr, output, ADDR_W bits: write address; wr_data, output, WORD_W bits: write data. Both are valid with wr_strobe.
REQ-013 The block SHALL have rd_strobe, output, 1 bit: one-cycle read request pulse; rd_addr, output, ADDR_W bits: valid with rd_strobe.
REQ-014 The block SHALL have rd_data, input, WORD_W bits: read data, which the user provides in the cycle after rd_strobe.
REQ-015 The block SHALL have frame_err, output, 1 bit: one-cycle pulse on a malformed frame.

Function
REQ-016 Frame format: FRAME_LEN = 1+ADDR_W+WORD_W bits; bit 0 is R/nW (1 = read), then the address MSB first, then the data MSB first.
REQ-017 spi_clk, spi_simo and spi_cs_n SHALL each pass through a 2-flop synchroniser; the sample edge is detected on the synchronised spi_clk.
REQ-018 The sample edge SHALL be rising when CPOL=0 and falling when CPOL=1; the SOMI shift edge is the opposite edge.
REQ-019 Host timing requirement: each spi_clk half-period and the cs-to-first-edge time SHALL be at least 4 master_clk periods.
REQ-020 State machine: IDLE -> CMD on cs falling edge; CMD -> ADDR after the R/nW bit; ADDR -> DATA after ADDR_W address bits; DATA -> DONE after WORD_W data bits; DONE -> IDLE on cs rising edge.
REQ-021 A bit counter SHALL count sample edges while cs is low; it is cleared on every cs falling edge.
REQ-022 Write: in DONE with R/nW=0, wr_strobe SHALL pulse exactly once, within 4 master_clk cycles of the final sample edge, carrying the shifted address and data.
REQ-023 Read: on entering DATA with R/nW=1, rd_strobe SHALL pulse once with rd_addr; the next cycle loads rd_data into the SOMI shift register; the MSB is driven on spi_somi before the first data sample edge.
REQ-024 The remaining read data bits SHALL shift out on each shift edge.
REQ-025 spi_somi SHALL be 0 outside read DATA.
REQ-026 Short frame (cs rises with count < FRAME_LEN): no wr_strobe SHALL occur and frame_err pulses; a read whose rd_strobe has already fired is not retracted.
REQ-027 Long frame (more than FRAME_LEN edges): the excess bits SHALL be ignored, the write still occurs once, frame_err pulses at cs rise, and spi_somi is 0 for the excess bits.
REQ-028 A cs falling edge SHALL restart the frame from CMD in any state.

Reset
REQ-029 Asserting reset at any time SHALL force IDLE, clear the counter, the shift registers and the synchroniser flops, and abort any frame in progress without a strobe.
REQ-030 Reset values: spi_somi=0, spi_somi_oe=0, wr_strobe=0, rd_strobe=0, frame_err=0, wr_addr=0, wr_data=0, rd_addr=0.
REQ-031 After reset deasserts, the first frame SHALL be accepted only after a cs falling edge is seen.

Configuration
REQ-032 Macro HOST_SPI_READBACK_EN: when defined, read frames behave as REQ-023 to REQ-025.
REQ-033 When HOST_SPI_READBACK_EN is undefined: rd_strobe is held 0, rd_data is ignored, spi_somi returns the bit sampled on spi_simo one sample edge earlier (loopback), and read frames raise no frame_err if their length is correct.

Verification
REQ-034 Write, defaults: frame R/nW=0, addr 0x15, data 0xBEEF -> exactly one wr_strobe with wr_addr=0x15 and wr_data=0xBEEF; frame_err stays 0.
REQ-035 Read, HOST_SPI_READBACK_EN defined: addr 0x02, rd_data=0xA5C3 -> rd_strobe once with rd_addr=0x02; host captures 0xA5C3 from spi_somi.
REQ-036 Short frame: cs rises after 10 edges -> no wr_strobe, one frame_err pulse; a following valid write to 0x01 with 0x0001 succeeds.
REQ-037 Reset mid-frame: reset asserted after 12 edges, then released, then a full write of 0x7F/0x1234 -> only that write is strobed.
REQ-038 CPOL=1, ADDR_W=4, WORD_W=8: write addr 0x9, data 0x3C -> wr_strobe with wr_addr=0x9 and wr_data=0x3C.
REQ-039 Long frame: 26 edges carrying write 0x10/0x00FF -> one wr_strobe with wr_addr=0x10 and wr_data=0x00FF, plus one frame_err pulse.
